// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor (result = a - b).
// Alignment and normalization move one bit per clock; start/busy/done handshake.
module fp_sub_seq #(
   parameter int MAX_ALIGN = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
   state_t state, nxt;
   logic        sl, ss, sg;
   logic [8:0]  el, es, ex, exd;
   logic [23:0] ml, ms, ma, mb;
   logic [24:0] sig, sum;
   logic [7:0]  cnt, ea, eb;
   logic [31:0] res_q, pk;
   logic        sa, sb, a_big, last_align;
   assign sa = a[31];
   assign sb = ~b[31];
   assign ea = a[30:23];
   assign eb = b[30:23];
   // Zero exponent flushes the operand (and any denormal) to zero
   assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
   assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
   assign a_big = {ea, ma} >= {eb, mb};
   assign sum = (sl == ss) ? {1'b0, ml} + {1'b0, ms} : {1'b0, ml} - {1'b0, ms};
   assign exd = ex - 9'd1;
   assign last_align = (es + 9'd1 == el) || (cnt == 8'(MAX_ALIGN - 1));
   assign pk = (sig == 25'd0 || ex == 9'd0) ? 32'd0 :
               (ex >= 9'd255) ? {sg, 8'hFF, 23'd0} : {sg, ex[7:0], sig[22:0]};
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? ALIGN : IDLE;
         ALIGN:   nxt = (el == es || last_align) ? ADD : ALIGN;
         ADD:     nxt = (sum == 25'd0 || sum[24:23] == 2'b01) ? DONE : NORM;
         NORM:    nxt = (sig[24] || sig[22] || exd == 9'd0) ? DONE : NORM;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      busy = state == ALIGN || state == ADD || state == NORM;
      done = state == DONE;
      result = done ? pk : res_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sl <= 1'b0;
         ss <= 1'b0;
         sg <= 1'b0;
         el <= 9'd0;
         es <= 9'd0;
         ex <= 9'd0;
         ml <= 24'd0;
         ms <= 24'd0;
         sig <= 25'd0;
         cnt <= 8'd0;
         res_q <= 32'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sl <= a_big ? sa : sb;
               ss <= a_big ? sb : sa;
               el <= {1'b0, a_big ? ea : eb};
               es <= {1'b0, a_big ? eb : ea};
               ml <= a_big ? ma : mb;
               ms <= a_big ? mb : ma;
               cnt <= 8'd0;
            end
            ALIGN: if (el != es) begin
               ms <= ms >> 1;
               es <= es + 9'd1;
               cnt <= cnt + 8'd1;
            end
            ADD: begin
               sig <= sum;
               ex <= el;
               sg <= sl;
            end
            NORM: begin
               sig <= sig[24] ? sig >> 1 : sig << 1;
               ex <= sig[24] ? ex + 9'd1 : exd;
            end
            DONE: res_q <= pk;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: directed vectors against a behavioural float-subtract model,
// with literal expectations pinning both the model and the DUT.
module tb_fp_sub_seq;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        busy, done;
   logic [31:0] result;
   int          pass_n = 0, tot_n = 0;
   logic [31:0] exp_res = 32'd0, hold = 32'd0;

   fp_sub_seq #(.MAX_ALIGN(25)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tot_n++;
      if (got === want) pass_n++;
      else $display("FAIL %s: got %h want %h", nm, got, want);
   endtask

   // Spec-level arithmetic: order by magnitude, align in one step, add, normalize.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output int lat);
      int ex, ey, mx, my, el, es, ml, ms, d, sum, e;
      bit sx, sy, sl, ss;
      sx = x[31];
      sy = ~y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = (ex == 0) ? 0 : int'(x[22:0]) + (1 << 23);
      my = (ey == 0) ? 0 : int'(y[22:0]) + (1 << 23);
      if (ex > ey || (ex == ey && mx >= my)) begin
         el = ex; ml = mx; sl = sx; es = ey; ms = my; ss = sy;
      end else begin
         el = ey; ml = my; sl = sy; es = ex; ms = mx; ss = sx;
      end
      d = el - es;
      lat = (d == 0) ? 1 : (d > 25 ? 25 : d);
      ms = (d >= 25) ? 0 : ms >> d;
      sum = (sl == ss) ? ml + ms : ml - ms;
      lat += 2;
      e = el;
      if (sum >= (1 << 24)) begin
         sum = sum >> 1;
         e++;
         lat++;
      end else if (sum != 0) begin
         while (sum < (1 << 23) && e > 0) begin
            sum = sum << 1;
            e--;
            lat++;
         end
      end
      if (sum == 0 || e == 0) r = 32'd0;
      else if (e >= 255) r = {sl, 8'hFF, 23'd0};
      else r = {sl, 8'(e), 23'(sum)};
   endfunction

   // Result must equal the model on done and stay put on every other cycle
   always @(negedge clk) if (!rst) begin
      if (done) begin
         chk("result_at_done", result, exp_res);
         hold = exp_res;
      end else chk("result_hold", result, hold);
   end

   task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] lit,
                     input int lit_lat, input bit poke);
      int lat, n;
      logic [31:0] r;
      model(x, y, r, lat);
      chk("model_vs_literal", r, lit);
      chk("model_lat_vs_literal", 32'(lat), 32'(lit_lat));
      exp_res = r;
      @(posedge clk); #1 a = x; b = y; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      n = 1;
      while (!done && n < 100) begin
         @(posedge clk); #1 n++;
         if (poke && n == 2) begin a = 32'h3F800000; b = 32'hBF800000; start = 1'b1; end
         if (poke && n == 3) start = 1'b0;
      end
      if (!done) begin
         tot_n++;
         $display("FAIL timeout: done not seen after %0d cycles, want %0d", n, lat);
      end else begin
         chk("latency", 32'(n), 32'(lat));
         chk("result_literal", result, lit);
         chk("busy_low_in_done", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("busy_low_after", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n, lat;
      logic [31:0] r;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      op(32'h42D2E666, 32'h41B28F5C, 32'h42A6428F, 4, 1'b0);
      op(32'h40B570A4, 32'h41E70A3D, 32'hC1B9AE14, 4, 1'b0);
      op(32'h3F800000, 32'h3F400000, 32'h3E800000, 5, 1'b0);
      op(32'h41200000, 32'h41200000, 32'h00000000, 3, 1'b0);
      op(32'h00000000, 32'h40400000, 32'hC0400000, 27, 1'b0);
      op(32'h40400000, 32'hC0400000, 32'h40C00000, 4, 1'b0);
      op(32'h4B800000, 32'h3F800000, 32'h4B800000, 26, 1'b1);
      op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, 1'b0);
      op(32'h00800001, 32'h00800000, 32'h00000000, 4, 1'b0);
      op(32'h3F800000, 32'h00000000, 32'h3F800000, 27, 1'b0);
      op(32'h42D2E666, 32'h41B28F5C, 32'h42A6428F, 4, 1'b0);

      // Asynchronous reset in the middle of a long ALIGN
      @(posedge clk); #1 a = 32'h4B800000; b = 32'h3F800000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("busy_before_rst", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      hold = 32'd0;
      @(posedge clk); #1 rst = 1'b0;
      op(32'h40B570A4, 32'h41E70A3D, 32'hC1B9AE14, 4, 1'b0);

      // start held through done: ignored in DONE, accepted one cycle later
      model(32'h3F800000, 32'h3F400000, r, lat);
      exp_res = r;
      @(posedge clk); #1 a = 32'h3F800000; b = 32'h3F400000; start = 1'b1;
      n = 0;
      do begin @(posedge clk); #1 n++; end while (!done && n < 100);
      chk("b2b_first_done", 32'(done), 32'd1);
      @(posedge clk); #1 chk("b2b_idle_after_done", 32'(busy), 32'd0);
      @(posedge clk); #1 chk("b2b_accept", 32'(busy), 32'd1);
      start = 1'b0;
      n = 1;
      while (!done && n < 100) begin @(posedge clk); #1 n++; end
      chk("b2b_latency", 32'(n), 32'(lat));
      repeat (3) @(posedge clk);
      #1 chk("b2b_final_result", result, 32'h3E800000);

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule

// File: doc/fp_sub_seq.md
Name: fp_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor; computes result = a - b.
- Companion to the combinational float adder in the arithmetic library.
- Alignment and normalization shift one bit per clock, trading latency for area.
- start/busy/done handshake so a controller or bench can sequence operations.

Parameters:
- MAX_ALIGN, 25, maximum right-shift steps applied to the smaller operand. Any larger exponent difference makes that operand contribute zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  minuend, IEEE-754 single
- b  input  32  subtrahend, IEEE-754 single
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when result becomes valid
- result  output  32  a - b; held stable until the next accepted start

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; done=0; result=32'h0.
  - Applies mid-operation as well; the in-flight operation is discarded.
- Operand capture on start in IDLE:
  - Register a and b; effective sign of b = ~b[31].
  - Exponent 0 means zero (denormals flushed).
  - Exponent 255 is not specially handled.
  - start while busy is ignored.
- States:
  - IDLE -> ALIGN on start.
  - ALIGN: order operands by magnitude (exponent, then mantissa). Large operand = L, small = S.
  - ALIGN: right-shift S's 24-bit significand (hidden 1 prepended) by one bit per cycle and increment its exponent, until the exponents match or MAX_ALIGN shifts are done.
  - ALIGN: shifted-out bits are discarded (truncation, round toward zero).
  - ALIGN with zero exponent difference takes 1 cycle. Otherwise it takes diff cycles (capped at MAX_ALIGN).
  - ADD (1 cycle): 25-bit sum if effective signs are equal, else L - S. Result sign = sign of L.
  - NORM:
    - Sum bit 24 set: one right shift, exponent +1, 1 cycle.
    - Otherwise left-shift one bit per cycle, exponent -1, until bit 23 is set.
    - Zero magnitude skips to DONE with result = +0.
  - DONE (1 cycle): drive result and pulse done=1, busy=0; next state IDLE.
- Boundaries:
  - Equal magnitudes with opposite effective signs: result 32'h00000000.
  - Either operand zero: result is the other operand with the effective sign applied.
  - Exponent overflow (>=255): result = sign, 8'hFF, mantissa 0.
  - Exponent underflow (reaches 0 while normalizing): result = +0.
  - start asserted in the same cycle as done: ignored, because the FSM is not yet in IDLE. It is accepted the following cycle if still high.
- Latency (start to done): 1 (ALIGN min) + extra align cycles + 1 (ADD) + norm shifts + 1. Worst case below 60 cycles.

Test Plan:
- 105.45 - 22.32:
  - Stimulus: a=32'h42D2E666, b=32'h41B28F5C, pulse start.
  - Response: done exactly once; result=32'h42A6428F (83.13); busy low afterwards.
- 5.67 - 28.88 (subtrahend larger):
  - Stimulus: a=32'h40B570A4, b=32'h41E70A3D.
  - Response: result=32'hC1B9AE14 (-23.21).
- Normalization:
  - Stimulus: a=32'h3F800000 (1.0), b=32'h3F400000 (0.75).
  - Response: result=32'h3E800000 (0.25); latency includes 2 left-shift cycles.
- Cancellation and zero handling:
  - a=b=32'h41200000 -> result 32'h00000000.
  - a=0, b=32'h40400000 -> result 32'hC0400000.
  - a=32'h40400000, b=32'hC0400000 -> result 32'h40C00000.
- Handshake and reset:
  - start pulsed again while busy: no effect on result.
  - rst asserted in ALIGN: busy, done and result go to 0 immediately (asynchronously).
  - New start after rst release completes correctly.
- Large exponent gap:
  - Stimulus: a=32'h4B800000 (2^24), b=32'h3F800000 (1.0).
  - Response: result=32'h4B800000, i.e. truncation drops b; ALIGN takes 24 cycles.
